// File: rtl/modular_inv_bin.sv
// Modular inverse out_data = opA^-1 mod opM using the binary extended Euclidean
// algorithm, one reduction step per clock, with operand checks and a step watchdog.
module modular_inv_bin #(
    parameter int WIDTH    = 256,
    parameter int MAX_ITER = 4 * WIDTH,
    parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opM,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] u_reg, u_next, v_reg, v_next;
    logic [WIDTH-1:0] x1_reg, x1_next, x2_reg, x2_next;
    logic [WIDTH-1:0] m_reg, m_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             err_reg, err_next;

    logic             done_hit, done_err;
    logic [WIDTH-1:0] done_val;
    logic [WIDTH:0]   x1_sum, x2_sum;

    // Odd coefficients are made even by adding M before halving; the extra bit keeps the carry.
    assign x1_sum = {1'b0, x1_reg} + {1'b0, m_reg};
    assign x2_sum = {1'b0, x2_reg} + {1'b0, m_reg};

    always_comb begin
        done_hit = 1'b0;
        done_err = 1'b0;
        done_val = '0;
        case (state_reg)
            CHECK: begin
                if (!m_reg[0] || m_reg < WIDTH'(3) || u_reg == '0 || u_reg >= m_reg) begin
                    done_hit = 1'b1;
                    done_err = 1'b1;
                end else if (u_reg == WIDTH'(1)) begin
                    done_hit = 1'b1;
                    done_val = WIDTH'(1);
                end
            end
            RUN: begin
                if (u_reg == WIDTH'(1)) begin
                    done_hit = 1'b1;
                    done_val = x1_reg;
                end else if (v_reg == WIDTH'(1)) begin
                    done_hit = 1'b1;
                    done_val = x2_reg;
                end else if (u_reg == '0 || v_reg == '0 || cnt_reg == CNT_W'(MAX_ITER)) begin
                    done_hit = 1'b1;
                    done_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = CHECK;
            CHECK:   state_next = done_hit ? DONE : RUN;
            RUN:     if (done_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
        out_data  = data_reg;
        out_err   = err_reg;
    end

    always_comb begin
        u_next    = u_reg;
        v_next    = v_reg;
        x1_next   = x1_reg;
        x2_next   = x2_reg;
        m_next    = m_reg;
        cnt_next  = cnt_reg;
        data_next = data_reg;
        err_next  = err_reg;
        if (state_reg == IDLE && in_valid) begin
            u_next   = opA;
            v_next   = opM;
            m_next   = opM;
            x1_next  = WIDTH'(1);
            x2_next  = '0;
            cnt_next = '0;
        end else if (done_hit) begin
            data_next = done_err ? '0 : done_val;
            err_next  = done_err;
        end else if (state_reg == RUN) begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (!u_reg[0]) begin
                u_next  = u_reg >> 1;
                x1_next = x1_reg[0] ? x1_sum[WIDTH:1] : (x1_reg >> 1);
            end else if (!v_reg[0]) begin
                v_next  = v_reg >> 1;
                x2_next = x2_reg[0] ? x2_sum[WIDTH:1] : (x2_reg >> 1);
            end else if (u_reg >= v_reg) begin
                u_next  = u_reg - v_reg;
                // Modulo-2^WIDTH wrap is harmless: the true result always lies in [0, M).
                x1_next = (x1_reg >= x2_reg) ? (x1_reg - x2_reg) : (x1_reg - x2_reg + m_reg);
            end else begin
                v_next  = v_reg - u_reg;
                x2_next = (x2_reg >= x1_reg) ? (x2_reg - x1_reg) : (x2_reg - x1_reg + m_reg);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            u_reg    <= '0;
            v_reg    <= '0;
            x1_reg   <= '0;
            x2_reg   <= '0;
            m_reg    <= '0;
            cnt_reg  <= '0;
            data_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            u_reg    <= u_next;
            v_reg    <= v_next;
            x1_reg   <= x1_next;
            x2_reg   <= x2_next;
            m_reg    <= m_next;
            cnt_reg  <= cnt_next;
            data_reg <= data_next;
            err_reg  <= err_next;
        end
    end

endmodule

// File: tb/tb_modular_inv_bin.sv
// Directed bench for modular_inv_bin: hand-computed small inverses, secp256k1 cases,
// operand rejection, back-pressure, mid-run reset and random vectors checked by a*inv mod p == 1.
module tb_modular_inv_bin;

    localparam int W = 256;
    localparam logic [W-1:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] opA = '0;
    logic [W-1:0] opM = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_err;

    int checks = 0;
    int errors = 0;

    modular_inv_bin #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .opA       (opA),
        .opM       (opM),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] modmul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
        logic [W+1:0] r;
        r = '0;
        for (int i = W - 1; i >= 0; i--) begin
            r = r << 1;
            if (r >= {2'b00, m}) r = r - {2'b00, m};
            if (b[i]) r = r + {2'b00, a};
            if (r >= {2'b00, m}) r = r - {2'b00, m};
        end
        return r[W-1:0];
    endfunction

    task automatic start(input string tag, input logic [W-1:0] a, input logic [W-1:0] m);
        @(negedge clk);
        check({tag, "_ready"}, W'(in_ready), W'(1));
        in_valid = 1'b1;
        opA = a;
        opM = m;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, output int lat);
        lat = 1;
        while (!out_valid && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_timeout"}, W'(out_valid), W'(1));
        $display("%s: out_data=%h out_err=%0d latency=%0d", tag, out_data, out_err, lat);
    endtask

    task automatic run_case(input string tag, input logic [W-1:0] a, input logic [W-1:0] m,
                            input logic [W-1:0] exp_data, input logic exp_err,
                            input int exact_lat, input int max_lat);
        int lat;
        start(tag, a, m);
        wait_out(tag, lat);
        check({tag, "_data"}, out_data, exp_data);
        check({tag, "_err"}, W'(out_err), W'(exp_err));
        if (exact_lat > 0) check({tag, "_lat"}, W'(lat), W'(exact_lat));
        else check({tag, "_latmax"}, W'(lat <= max_lat), W'(1));
        @(negedge clk);
        check({tag, "_pulse"}, W'(out_valid), W'(0));
        check({tag, "_idle"}, W'(in_ready), W'(1));
        check({tag, "_hold"}, out_data, exp_data);
    endtask

    initial begin
        int lat;
        logic [W-1:0] a;

        repeat (2) @(negedge clk);
        check("rst_ready", W'(in_ready), W'(1));
        check("rst_valid", W'(out_valid), W'(0));
        check("rst_data", out_data, '0);
        check("rst_err", W'(out_err), W'(0));
        rst = 1'b0;

        run_case("t1_3_7", W'(3), W'(7), W'(5), 1'b0, 0, 20);
        run_case("inv_2_9", W'(2), W'(9), W'(5), 1'b0, 0, 30);
        run_case("inv_4_9", W'(4), W'(9), W'(7), 1'b0, 0, 30);
        run_case("inv_10_17", W'(10), W'(17), W'(12), 1'b0, 0, 40);
        run_case("t2_2_p", W'(2), P, (P + W'(1)) >> 1, 1'b0, 0, 514);
        run_case("t3_gcd", W'(6), W'(9), '0, 1'b1, 0, 40);
        run_case("t3_a0", W'(0), W'(7), '0, 1'b1, 2, 0);
        run_case("t3_m8", W'(3), W'(8), '0, 1'b1, 2, 0);
        run_case("m1", W'(0), W'(1), '0, 1'b1, 2, 0);
        run_case("a_ge_m", W'(7), W'(7), '0, 1'b1, 2, 0);
        run_case("t4_one", W'(1), P, W'(1), 1'b0, 2, 0);
        run_case("t4_pm1", P - W'(1), P, P - W'(1), 1'b0, 0, 2 + 4 * W + 1);

        // Second operand set held on in_valid during a run must wait for in_ready.
        @(negedge clk);
        in_valid = 1'b1;
        opA = W'(3);
        opM = W'(7);
        @(negedge clk);
        opA = W'(10);
        opM = W'(17);
        wait_out("t5_first", lat);
        check("t5_first_data", out_data, W'(5));
        @(negedge clk);
        check("t5_ready", W'(in_ready), W'(1));
        @(negedge clk);
        in_valid = 1'b0;
        wait_out("t5_second", lat);
        check("t5_second_data", out_data, W'(12));
        check("t5_second_err", W'(out_err), W'(0));

        // Reset during a long run must abort it cleanly.
        start("t6", 256'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321_1111_2222_3333_4444_5555_6666_7777_8889, P);
        repeat (20) @(negedge clk);
        check("t6_running", W'(out_valid), W'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_ready", W'(in_ready), W'(1));
        check("t6_valid", W'(out_valid), W'(0));
        run_case("t6_fresh", W'(3), W'(7), W'(5), 1'b0, 0, 20);

        for (int n = 0; n < 30; n++) begin
            a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (a >= P) a = a - P;
            if (a == '0) a = W'(1);
            start("rand", a, P);
            wait_out("rand", lat);
            check("rand_err", W'(out_err), W'(0));
            check("rand_prod", modmul(a, out_data, P), W'(1));
            check("rand_lat", W'(lat <= 2 + 4 * W + 1), W'(1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
